// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - Operand, control and HI/LO bus of the multiply/divide unit
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_op1;
    logic [WIDTH-1:0] i_op2;
    logic             i_mthi;
    logic             i_mtlo;
    logic [WIDTH-1:0] i_wdata;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    modport slave (
        input  i_start, i_op, i_op1, i_op2, i_mthi, i_mtlo, i_wdata,
        output o_busy, o_done, o_hi, o_lo
    );

    modport master (
        output i_start, i_op, i_op1, i_op2, i_mthi, i_mtlo, i_wdata,
        input  o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q;
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   raw_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic               last_iter;
    logic               start_signed;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign last_iter    = (count_q == CW'(WIDTH - 1));
    assign start_signed = ~bus.i_op[0];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> RUN on start, RUN for WIDTH iterations, one FIX cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.i_start) state_d = S_RUN;
            S_RUN:   if (last_iter)   state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: busy follows the registered state, done is a registered pulse
    always_comb begin
        bus.o_busy = (state_q != S_IDLE);
        bus.o_done = done_q;
        bus.o_hi   = hi_q;
        bus.o_lo   = lo_q;
    end

    // One iteration step on magnitudes and the sign/zero fix-up of the result
    always_comb begin
        // Shift-add: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole product right by one.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        // Restoring divide: remainder lives in the upper half, quotient bits
        // shift into the lower half; the dividend supplies bits MSB first.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
        mul_res   = neg_res_q ? -acc_q : acc_q;
        if (is_div_q) begin
            if (b_q == '0) begin
                fix_hi = raw_q;
                fix_lo = '1;
            end else begin
                fix_hi = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                fix_lo = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            end
        end else begin
            fix_hi = mul_res[2*WIDTH-1:WIDTH];
            fix_lo = mul_res[WIDTH-1:0];
        end
    end

    // Datapath: operand capture, iteration, HI/LO writes and done pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            raw_q     <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == S_FIX);
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        is_div_q  <= bus.i_op[1];
                        neg_res_q <= start_signed & (bus.i_op1[WIDTH-1] ^ bus.i_op2[WIDTH-1]);
                        neg_rem_q <= start_signed & bus.i_op1[WIDTH-1];
                        a_q       <= (start_signed & bus.i_op1[WIDTH-1]) ? -bus.i_op1 : bus.i_op1;
                        b_q       <= (start_signed & bus.i_op2[WIDTH-1]) ? -bus.i_op2 : bus.i_op2;
                        raw_q     <= bus.i_op1;
                        acc_q     <= '0;
                        count_q   <= '0;
                    end else begin
                        if (bus.i_mthi) hi_q <= bus.i_wdata;
                        if (bus.i_mtlo) lo_q <= bus.i_wdata;
                    end
                end
                S_RUN: begin
                    count_q <= count_q + 1'b1;
                    if (is_div_q) begin
                        acc_q <= div_next;
                        a_q   <= a_q << 1;
                    end else begin
                        acc_q <= mul_next;
                        b_q   <= b_q >> 1;
                    end
                end
                S_FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - Scoreboard bench for muldiv_unit
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          busy_run = 0;
    logic        prev_done = 1'b0;

    function automatic logic [63:0] ref_model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: p = 64'(sa * sb);
            2'd1: p = {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (rst) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (bus.o_busy) busy_run++;
            if (bus.o_done) begin
                check("done_single_cycle", 64'(prev_done), 64'd0);
                check("busy_cycles", 64'(busy_run), 64'd33);
                busy_run = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%h expected=none", {bus.o_hi, bus.o_lo});
                end else begin
                    check("result_hi_lo", {bus.o_hi, bus.o_lo}, exp_q.pop_front());
                end
            end
            prev_done = bus.o_done;
        end
    end

    // Called at a negedge; returns #1 after the edge that samples start
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_it, output logic [63:0] e);
        e = ref_model(op, a, b);
        if (expect_it) exp_q.push_back(e);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_op1   = a;
        bus.i_op2   = b;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit seen;
        seen = 0;
        lat  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (bus.o_done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d expected=done", lat);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int lat;
        issue(op, a, b, 1'b1, e);
        wait_done(lat);
        check("done_latency", 64'(lat), 64'd34);
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    task automatic mt(input bit hi_en, input bit lo_en, input logic [31:0] d);
        bus.i_mthi  = hi_en;
        bus.i_mtlo  = lo_en;
        bus.i_wdata = d;
        @(posedge clk);
        #1;
        bus.i_mthi = 1'b0;
        bus.i_mtlo = 1'b0;
        if (hi_en) m_hi = d;
        if (lo_en) m_lo = d;
        @(negedge clk);
        check("mt_hi", 64'(bus.o_hi), 64'(m_hi));
        check("mt_lo", 64'(bus.o_lo), 64'(m_lo));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e;
        int lat;
        logic [31:0] a, b;
        logic [1:0]  op;

        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_op = '0; bus.i_op1 = '0; bus.i_op2 = '0;
        bus.i_mthi = 1'b0; bus.i_mtlo = 1'b0; bus.i_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hi", 64'(bus.o_hi), 64'd0);
        check("reset_lo", 64'(bus.o_lo), 64'd0);
        check("reset_busy", 64'(bus.o_busy), 64'd0);
        check("reset_done", 64'(bus.o_done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, including back-to-back DIVU started in the done cycle
        do_op(2'd0, 32'hFFFF_FFFD, 32'd5);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(2'd3, 32'd100, 32'd7);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        do_op(2'd2, 32'd7, 32'hFFFF_FFFE);
        do_op(2'd3, 32'd100, 32'd0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'd2, 32'hFFFF_FFF0, 32'd0);

        // MTHI / MTLO in IDLE
        mt(1'b1, 1'b0, 32'hA5A5_A5A5);
        mt(1'b0, 1'b1, 32'h5A5A_0F0F);
        mt(1'b1, 1'b1, 32'h1234_5678);

        // Start wins over MTHI in the same cycle; requests during RUN are ignored
        bus.i_mthi  = 1'b1;
        bus.i_wdata = 32'hDEAD_BEEF;
        issue(2'd1, 32'd2, 32'd3, 1'b1, e);
        bus.i_mthi = 1'b0;
        @(negedge clk);
        check("start_priority_hi", 64'(bus.o_hi), 64'(m_hi));
        check("run_busy", 64'(bus.o_busy), 64'd1);
        bus.i_mtlo  = 1'b1;
        bus.i_start = 1'b1;
        bus.i_wdata = 32'hCAFE_F00D;
        bus.i_op    = 2'd0;
        bus.i_op1   = 32'd9;
        bus.i_op2   = 32'd9;
        repeat (5) begin
            @(negedge clk);
            check("run_lo_hold", 64'(bus.o_lo), 64'(m_lo));
        end
        bus.i_mtlo  = 1'b0;
        bus.i_start = 1'b0;
        wait_done(lat);
        m_hi = e[63:32];
        m_lo = e[31:0];
        repeat (40) @(negedge clk);
        check("idle_after_ignored_start", 64'(bus.o_busy), 64'd0);

        // Reset mid-operation aborts with no HI/LO write and no done pulse
        issue(2'd0, 32'd3, 32'd4, 1'b0, e);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_hi", 64'(bus.o_hi), 64'd0);
        check("abort_lo", 64'(bus.o_lo), 64'd0);
        check("abort_busy", 64'(bus.o_busy), 64'd0);
        check("abort_done", 64'(bus.o_done), 64'd0);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        repeat (5) @(negedge clk);
        do_op(2'd0, 32'd3, 32'd4);

        // Randomized operations with occasional MTHI/MTLO between them
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 4) == 0)
                mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            do_op(op, a, b);
        end

        @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the unpipelined MIPS core's execute stage. It takes the same two register-file operands as the ALU and runs MULT, MULTU, DIV and DIVU over multiple cycles. Results go into the architectural HI/LO registers, which feed the writeback mux for MFHI/MFLO. The control unit stalls PC update while `o_busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width. Only 32 is supported in this core; the iteration counter is sized to count `WIDTH`.

Ports:
- `i_clk`, input, 1: clock; all state changes on the rising edge.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_start`, input, 1: start request. Sampled only in IDLE.
- `i_op`, input, 2: operation select. 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- `i_op1`, input, WIDTH: rs operand (multiplicand or dividend).
- `i_op2`, input, WIDTH: rt operand (multiplier or divisor).
- `i_mthi`, input, 1: write `i_wdata` into HI (MTHI).
- `i_mtlo`, input, 1: write `i_wdata` into LO (MTLO).
- `i_wdata`, input, WIDTH: data for MTHI/MTLO.
- `o_busy`, output, 1: operation in progress.
- `o_done`, output, 1: one-cycle pulse in the cycle after HI/LO are updated by an operation.
- `o_hi`, output, WIDTH: HI register.
- `o_lo`, output, WIDTH: LO register.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE:**
  - If `i_start`=1, latch `i_op`, the operand magnitudes (two's-complement abs for signed ops), the result sign flags and the raw `i_op1`. Clear the accumulator, set count=0, go to RUN.
  - Otherwise `i_mthi`/`i_mtlo` write HI/LO. Both may be asserted together.
  - `i_start` has priority: MTHI/MTLO in the same cycle as `i_start` are ignored.
- **RUN:** one iteration per cycle, count 0..WIDTH-1. After the last iteration, go to FIX.
  - Multiply: shift-add on magnitudes into a 2·WIDTH product.
  - Divide: restoring shift-subtract on magnitudes, producing quotient and remainder.
- **FIX:** apply the sign correction and write HI/LO, then return to IDLE.
  - Multiply: {HI,LO} = product, negated (2·WIDTH two's complement) if the operand signs differ on MULT.
  - Divide: LO = quotient, negated if the signs differ on DIV; HI = remainder, negated if the dividend is negative on DIV.
- Divide by zero (DIV or DIVU): HI = raw `i_op1`, LO = {WIDTH{1'b1}}. This overrides the sign fix.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0. This falls out of unsigned-magnitude arithmetic; no special case.
- While in RUN/FIX:
  - `i_start`, `i_mthi` and `i_mtlo` are ignored.
  - `o_hi`/`o_lo` hold their previous values until the FIX edge.
- **Reset** (any state, including mid-operation): state=IDLE, HI=0, LO=0, `o_busy`=0, `o_done`=0, count=0. An operation in flight is aborted with no HI/LO write.

## Timing
- E0 = the edge that samples `i_start`=1 in IDLE.
- E1..E32: RUN iterations.
- E33: FIX edge; writes HI/LO.
- `o_busy`=1 from after E0 through the cycle ending at E33: 33 cycles, registered.
- `o_done`=1 for exactly the one cycle after E33. New HI/LO values are visible in that same cycle.
- Back-to-back: `i_start` sampled at E34 (state IDLE, `o_done`=1) is accepted; the next result is written at E67.
- MTHI/MTLO in IDLE: value visible on `o_hi`/`o_lo` the cycle after the edge. Zero-cycle latency to busy: none.
- `o_busy` deasserts in the same cycle `o_done` asserts.

## Test plan
- MULT, `i_op1`=32'hFFFFFFFD (−3), `i_op2`=5 -> at E33 HI=32'hFFFFFFFF, LO=32'hFFFFFFF1; `o_done` high exactly one cycle; `o_busy` high 33 cycles.
- MULTU, both operands 32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001. Then a back-to-back DIVU 100/7 started in the `o_done` cycle -> LO=14, HI=2 at E67.
- DIV −7/2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIV 7/−2 -> LO=32'hFFFFFFFD, HI=1.
- DIVU 100/0 -> HI=32'h00000064, LO=32'hFFFFFFFF. DIV 32'h80000000/32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- MTHI 32'hA5A5A5A5 in IDLE -> `o_hi`=32'hA5A5A5A5 next cycle. During RUN, `i_mtlo`=1 and `i_start`=1 with new operands -> both ignored; LO changes only at E33, with the original result.
- Start MULT 3×4, assert `i_rst` at E10 -> next cycle HI=LO=0, `o_busy`=0, no `o_done` pulse. A new MULT 3×4 afterwards -> LO=12, HI=0.
